// File: rtl/video_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// video_frame_buffer_if
// Purpose : CPU-side word bus into the double-buffered frame buffer.
// Signals : bus_write_enable  - write strobe, one write per asserted cycle
//           bus_read_enable   - read strobe, data returned one cycle later
//           bus_address[17:0] - byte offset; [17] frame, [16:2] word index
//           bus_write_data    - four RGB332 pixels, byte n -> pixel n of word
//           bus_byte_enable   - per-pixel write enable
//           bus_read_data     - four pixels of the last read word
// Modports: master (CPU side), slave (frame buffer side)
// ---------------------------------------------------------------------------
interface video_frame_buffer_if;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   logic              bus_write_enable;
   logic              bus_read_enable;
   logic [ADDR_W-1:0] bus_address;
   logic [DATA_W-1:0] bus_write_data;
   logic [BE_W-1:0]   bus_byte_enable;
   logic [DATA_W-1:0] bus_read_data;

   modport master (
      output bus_write_enable,
      output bus_read_enable,
      output bus_address,
      output bus_write_data,
      output bus_byte_enable,
      input  bus_read_data
   );

   modport slave (
      input  bus_write_enable,
      input  bus_read_enable,
      input  bus_address,
      input  bus_write_data,
      input  bus_byte_enable,
      output bus_read_data
   );

endinterface

// File: rtl/video_frame_buffer.sv
// ---------------------------------------------------------------------------
// video_frame_buffer
// Purpose : Two 320x240 RGB332 frames written by the CPU over a word bus and
//           read by the VGA driver with 2x upscaling to 640x480 and RGB888
//           expansion. The displayed frame flips only on vsync falling edge.
// Ports   : clock, reset (sync, active-low)
//           bus                   - CPU word bus (slave modport)
//           display_frame_request - frame the CPU wants shown (level)
//           vga_vertical_sync     - driver vsync, active-low
//           pixel_x_pos/y_pos     - driver position, 640x480 space
//           pixel_red/green/blue  - expanded colour, 2 cycles after position
//           display_frame         - frame currently displayed
//           frame_swapped         - one-cycle pulse when display_frame changes
// ---------------------------------------------------------------------------
module video_frame_buffer (
   input  logic                      clock,
   input  logic                      reset,
   video_frame_buffer_if.slave       bus,
   input  logic                      display_frame_request,
   input  logic                      vga_vertical_sync,
   input  logic [9:0]                pixel_x_pos,
   input  logic [9:0]                pixel_y_pos,
   output logic [7:0]                pixel_red,
   output logic [7:0]                pixel_green,
   output logic [7:0]                pixel_blue,
   output logic                      display_frame,
   output logic                      frame_swapped
);

   localparam int unsigned FB_WIDTH   = 320;
   localparam int unsigned FB_HEIGHT  = 240;
   localparam int unsigned FB_PIXELS  = FB_WIDTH * FB_HEIGHT;
   localparam int unsigned FB_WORDS   = FB_PIXELS / 4;
   localparam int unsigned BANK_DEPTH = 2 * FB_WORDS;
   localparam int unsigned BANK_AW    = $clog2(BANK_DEPTH);
   localparam int unsigned IDX_W      = 17;
   localparam int unsigned WORD_W     = 15;
   localparam int unsigned POS_W      = 9;

   // Pixel storage: four byte-wide banks, bank n holds pixel n of every word.
   // Bank address = word index, offset by FB_WORDS for frame 1.
   logic [7:0] ram_mem [4][BANK_DEPTH];

   // Bus-side decode
   logic [WORD_W-1:0]  bus_word;
   logic               bus_in_range;
   logic [BANK_AW-1:0] bus_bank_addr;

   // Display pipeline
   logic [POS_W-1:0]   fb_x;
   logic [POS_W-1:0]   fb_y;
   logic [IDX_W-1:0]   disp_idx_d,   disp_idx_q;
   logic               disp_frame_d, disp_frame_q;
   logic [BANK_AW-1:0] disp_bank_addr;
   logic               disp_in_range;
   logic [7:0]         pix_q;

   // Frame swap control
   logic               vsync_prev_d,    vsync_prev_q;
   logic               display_frame_d, display_frame_q;
   logic               frame_swapped_d, frame_swapped_q;
   logic               vsync_fall;

   logic [31:0]        bus_read_data_q;

   // Address bits that carry no information here
   logic               unused_bits;
   assign unused_bits = ^{bus.bus_address[1:0], pixel_x_pos[0], pixel_y_pos[0]};

   // Bus address decode; a word is either wholly inside or wholly outside a frame
   always_comb begin
      bus_word      = bus.bus_address[16:2];
      bus_in_range  = (bus_word < WORD_W'(FB_WORDS));
      bus_bank_addr = BANK_AW'(bus_word)
                    + (bus.bus_address[17] ? BANK_AW'(FB_WORDS) : {BANK_AW{1'b0}});
   end

   // Stage 1: 2x downscale of the driver position and linear index (y*320 + x)
   always_comb begin
      fb_x         = pixel_x_pos[9:1];
      fb_y         = pixel_y_pos[9:1];
      disp_idx_d   = (IDX_W'(fb_y) << 8) + (IDX_W'(fb_y) << 6) + IDX_W'(fb_x);
      disp_frame_d = display_frame_q;
   end

   // Stage 2 address from the registered index and frame
   always_comb begin
      disp_in_range  = (disp_idx_q < IDX_W'(FB_PIXELS));
      disp_bank_addr = BANK_AW'(disp_idx_q[16:2])
                     + (disp_frame_q ? BANK_AW'(FB_WORDS) : {BANK_AW{1'b0}});
   end

   // Deferred page flip on vsync falling edge
   always_comb begin
      vsync_prev_d    = vga_vertical_sync;
      display_frame_d = display_frame_q;
      frame_swapped_d = 1'b0;
      vsync_fall      = vsync_prev_q & ~vga_vertical_sync;
      if (vsync_fall && (display_frame_request != display_frame_q)) begin
         display_frame_d = display_frame_request;
         frame_swapped_d = 1'b1;
      end
   end

   // RAM port A write; contents are never reset
   always_ff @(posedge clock) begin
      if (bus.bus_write_enable && bus_in_range) begin
         for (int n = 0; n < 4; n++) begin
            if (bus.bus_byte_enable[n]) begin
               ram_mem[n][bus_bank_addr] <= bus.bus_write_data[8*n +: 8];
            end
         end
      end
   end

   // Control, pipeline and RAM output registers; reads see pre-write data
   always_ff @(posedge clock) begin
      if (!reset) begin
         vsync_prev_q    <= 1'b1;
         display_frame_q <= 1'b0;
         frame_swapped_q <= 1'b0;
         disp_idx_q      <= '0;
         disp_frame_q    <= 1'b0;
         pix_q           <= 8'h00;
         bus_read_data_q <= 32'h0;
      end else begin
         vsync_prev_q    <= vsync_prev_d;
         display_frame_q <= display_frame_d;
         frame_swapped_q <= frame_swapped_d;
         disp_idx_q      <= disp_idx_d;
         disp_frame_q    <= disp_frame_d;
         pix_q           <= disp_in_range ? ram_mem[disp_idx_q[1:0]][disp_bank_addr] : 8'h00;
         if (bus.bus_read_enable) begin
            bus_read_data_q <= bus_in_range ? {ram_mem[3][bus_bank_addr],
                                               ram_mem[2][bus_bank_addr],
                                               ram_mem[1][bus_bank_addr],
                                               ram_mem[0][bus_bank_addr]}
                                            : 32'h0;
         end
      end
   end

   // RGB332 -> RGB888 by bit replication
   always_comb begin
      pixel_red   = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
      pixel_green = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
      pixel_blue  = {pix_q[1:0], pix_q[1:0], pix_q[1:0], pix_q[1:0]};
   end

   assign bus.bus_read_data = bus_read_data_q;
   assign display_frame     = display_frame_q;
   assign frame_swapped     = frame_swapped_q;

endmodule

// File: tb/tb_video_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_video_frame_buffer
// Purpose : Directed bench for video_frame_buffer: bus write/read, colour
//           expansion, upscale addressing, byte enables, range clipping and
//           vsync-deferred page flipping.
// ---------------------------------------------------------------------------
module tb_video_frame_buffer;

   logic       clock;
   logic       reset;
   logic       display_frame_request;
   logic       vga_vertical_sync;
   logic [9:0] pixel_x_pos;
   logic [9:0] pixel_y_pos;
   logic [7:0] pixel_red;
   logic [7:0] pixel_green;
   logic [7:0] pixel_blue;
   logic       display_frame;
   logic       frame_swapped;

   int n_checks;
   int n_fail;

   video_frame_buffer_if bus_if ();

   video_frame_buffer dut (
      .clock                 (clock),
      .reset                 (reset),
      .bus                   (bus_if.slave),
      .display_frame_request (display_frame_request),
      .vga_vertical_sync     (vga_vertical_sync),
      .pixel_x_pos           (pixel_x_pos),
      .pixel_y_pos           (pixel_y_pos),
      .pixel_red             (pixel_red),
      .pixel_green           (pixel_green),
      .pixel_blue            (pixel_blue),
      .display_frame         (display_frame),
      .frame_swapped         (frame_swapped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [17:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus_if.bus_address      = addr;
      bus_if.bus_write_data   = data;
      bus_if.bus_byte_enable  = be;
      bus_if.bus_write_enable = 1'b1;
      step();
      bus_if.bus_write_enable = 1'b0;
      bus_if.bus_byte_enable  = 4'h0;
   endtask

   task automatic bus_read(input logic [17:0] addr, output logic [31:0] data);
      bus_if.bus_address     = addr;
      bus_if.bus_read_enable = 1'b1;
      step();
      bus_if.bus_read_enable = 1'b0;
      data = bus_if.bus_read_data;
   endtask

   // Present a position and wait the two-cycle display latency
   task automatic show_pixel(input logic [9:0] x, input logic [9:0] y, output logic [23:0] rgb);
      pixel_x_pos = x;
      pixel_y_pos = y;
      step();
      step();
      rgb = {pixel_red, pixel_green, pixel_blue};
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({pixel_red, pixel_green, pixel_blue} !== 24'h0) begin
         n_fail++; $display("FAIL reset_rgb: got %h expected %h", {pixel_red, pixel_green, pixel_blue}, 24'h0);
      end
      n_checks++;
      if (display_frame !== 1'b0) begin
         n_fail++; $display("FAIL reset_display_frame: got %b expected 0", display_frame);
      end
      n_checks++;
      if (frame_swapped !== 1'b0) begin
         n_fail++; $display("FAIL reset_frame_swapped: got %b expected 0", frame_swapped);
      end
      n_checks++;
      if (bus_if.bus_read_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_read_data: got %h expected 0", bus_if.bus_read_data);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b0 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL release_flags[%0d]: got df=%b fs=%b expected 0/0", i, display_frame, frame_swapped);
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic [23:0] rgb;
      bus_write(18'd0, 32'hE01C03FF, 4'hF);
      bus_read(18'd0, rd);
      n_checks++;
      if (rd !== 32'hE01C03FF) begin
         n_fail++; $display("FAIL wr_rd_word0: got %h expected %h", rd, 32'hE01C03FF);
      end
      show_pixel(10'd0, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'hFFFFFF) begin
         n_fail++; $display("FAIL rgb_white: got %h expected %h", rgb, 24'hFFFFFF);
      end
      show_pixel(10'd2, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'h0000FF) begin
         n_fail++; $display("FAIL rgb_blue: got %h expected %h", rgb, 24'h0000FF);
      end
      show_pixel(10'd5, 10'd1, rgb);
      n_checks++;
      if (rgb !== 24'h00FF00) begin
         n_fail++; $display("FAIL rgb_green: got %h expected %h", rgb, 24'h00FF00);
      end
      show_pixel(10'd7, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'hFF0000) begin
         n_fail++; $display("FAIL rgb_red: got %h expected %h", rgb, 24'hFF0000);
      end
      // 8'h6D: r=011, g=011, b=01 at fb (0,1), index 320
      bus_write(18'd320, 32'h0000006D, 4'hF);
      show_pixel(10'd1, 10'd3, rgb);
      n_checks++;
      if (rgb !== 24'h6D6D55) begin
         n_fail++; $display("FAIL rgb_mid: got %h expected %h", rgb, 24'h6D6D55);
      end
      // Read and write of the same word in one cycle returns the old word
      bus_if.bus_address      = 18'd320;
      bus_if.bus_write_data   = 32'h11223344;
      bus_if.bus_byte_enable  = 4'hF;
      bus_if.bus_write_enable = 1'b1;
      bus_if.bus_read_enable  = 1'b1;
      step();
      bus_if.bus_write_enable = 1'b0;
      bus_if.bus_read_enable  = 1'b0;
      bus_if.bus_byte_enable  = 4'h0;
      n_checks++;
      if (bus_if.bus_read_data !== 32'h0000006D) begin
         n_fail++; $display("FAIL rw_same_word: got %h expected %h", bus_if.bus_read_data, 32'h0000006D);
      end
      bus_read(18'd320, rd);
      n_checks++;
      if (rd !== 32'h11223344) begin
         n_fail++; $display("FAIL rw_after: got %h expected %h", rd, 32'h11223344);
      end
      // 8'h44: r=010 -> 49, g=001 -> 24, b=00
      show_pixel(10'd0, 10'd2, rgb);
      n_checks++;
      if (rgb !== 24'h492400) begin
         n_fail++; $display("FAIL rgb_after_rw: got %h expected %h", rgb, 24'h492400);
      end
   endtask

   task automatic test_upscale();
      logic [23:0] rgb;
      bus_write(18'd76796, 32'hE0000000, 4'b1000);
      show_pixel(10'd638, 10'd478, rgb);
      n_checks++;
      if (rgb !== 24'hFF0000) begin
         n_fail++; $display("FAIL last_pixel_even: got %h expected %h", rgb, 24'hFF0000);
      end
      show_pixel(10'd639, 10'd479, rgb);
      n_checks++;
      if (rgb !== 24'hFF0000) begin
         n_fail++; $display("FAIL last_pixel_odd: got %h expected %h", rgb, 24'hFF0000);
      end
   endtask

   task automatic test_byte_enable_range();
      logic [31:0] rd;
      logic [23:0] rgb;
      bus_write(18'd0, 32'h00000000, 4'hF);
      bus_write(18'd0, 32'hFFFFFFFF, 4'b0101);
      bus_read(18'd0, rd);
      n_checks++;
      if (rd !== 32'h00FF00FF) begin
         n_fail++; $display("FAIL byte_enable: got %h expected %h", rd, 32'h00FF00FF);
      end
      bus_write(18'h20000, 32'h12345678, 4'hF);
      bus_write(18'd76800, 32'hAABBCCDD, 4'hF);
      bus_read(18'd76800, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++; $display("FAIL oob_read_f0: got %h expected 0", rd);
      end
      bus_read(18'h20000, rd);
      n_checks++;
      if (rd !== 32'h12345678) begin
         n_fail++; $display("FAIL oob_no_alias: got %h expected %h", rd, 32'h12345678);
      end
      bus_read(18'h20000 + 18'd76800, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++; $display("FAIL oob_read_f1: got %h expected 0", rd);
      end
      bus_read(18'h3FFFC, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++; $display("FAIL oob_read_max: got %h expected 0", rd);
      end
      show_pixel(10'd2, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'h000000) begin
         n_fail++; $display("FAIL be_disp_px1: got %h expected 0", rgb);
      end
   endtask

   task automatic test_deferred_swap();
      logic [23:0] rgb;
      bus_write(18'h20000, 32'h0000001C, 4'b0001);
      vga_vertical_sync     = 1'b1;
      display_frame_request = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b0 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL swap_early[%0d]: got df=%b fs=%b expected 0/0", i, display_frame, frame_swapped);
         end
      end
      show_pixel(10'd0, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'hFFFFFF) begin
         n_fail++; $display("FAIL swap_old_frame: got %h expected %h", rgb, 24'hFFFFFF);
      end
      vga_vertical_sync = 1'b0;
      step();
      n_checks++;
      if (display_frame !== 1'b1 || frame_swapped !== 1'b1) begin
         n_fail++; $display("FAIL swap_edge: got df=%b fs=%b expected 1/1", display_frame, frame_swapped);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b1 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL swap_after[%0d]: got df=%b fs=%b expected 1/0", i, display_frame, frame_swapped);
         end
      end
      vga_vertical_sync = 1'b1;
      show_pixel(10'd0, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'h00FF00) begin
         n_fail++; $display("FAIL swap_new_frame: got %h expected %h", rgb, 24'h00FF00);
      end
   endtask

   task automatic test_vsync_low_hold();
      logic [23:0] rgb;
      vga_vertical_sync = 1'b0;
      step();
      n_checks++;
      if (display_frame !== 1'b1 || frame_swapped !== 1'b0) begin
         n_fail++; $display("FAIL same_req_edge: got df=%b fs=%b expected 1/0", display_frame, frame_swapped);
      end
      display_frame_request = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b1 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL hold_low[%0d]: got df=%b fs=%b expected 1/0", i, display_frame, frame_swapped);
         end
      end
      vga_vertical_sync = 1'b1;
      step();
      vga_vertical_sync = 1'b0;
      step();
      n_checks++;
      if (display_frame !== 1'b0 || frame_swapped !== 1'b1) begin
         n_fail++; $display("FAIL swap_back: got df=%b fs=%b expected 0/1", display_frame, frame_swapped);
      end
      vga_vertical_sync = 1'b1;
      show_pixel(10'd0, 10'd0, rgb);
      n_checks++;
      if (rgb !== 24'hFFFFFF || frame_swapped !== 1'b0) begin
         n_fail++; $display("FAIL swap_back_rgb: got %h fs=%b expected %h fs=0", rgb, frame_swapped, 24'hFFFFFF);
      end
   endtask

   task automatic test_glitch_request();
      vga_vertical_sync = 1'b1;
      step();
      display_frame_request = 1'b1;
      step();
      step();
      display_frame_request = 1'b0;
      step();
      vga_vertical_sync = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b0 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL glitch[%0d]: got df=%b fs=%b expected 0/0", i, display_frame, frame_swapped);
         end
      end
      vga_vertical_sync = 1'b1;
      step();
   endtask

   task automatic test_reset_midframe();
      logic [23:0] rgb;
      display_frame_request = 1'b1;
      vga_vertical_sync     = 1'b0;
      step();
      vga_vertical_sync = 1'b1;
      step();
      n_checks++;
      if (display_frame !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_df: got %b expected 1", display_frame);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (display_frame !== 1'b0 || {pixel_red, pixel_green, pixel_blue} !== 24'h0) begin
         n_fail++; $display("FAIL midframe_reset: got df=%b rgb=%h expected 0/0", display_frame, {pixel_red, pixel_green, pixel_blue});
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (display_frame !== 1'b0 || frame_swapped !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_hold[%0d]: got df=%b fs=%b expected 0/0", i, display_frame, frame_swapped);
         end
      end
      vga_vertical_sync = 1'b0;
      step();
      n_checks++;
      if (display_frame !== 1'b1 || frame_swapped !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_swap: got df=%b fs=%b expected 1/1", display_frame, frame_swapped);
      end
      vga_vertical_sync = 1'b1;
      show_pixel(10'd1, 10'd1, rgb);
      n_checks++;
      if (rgb !== 24'h00FF00) begin
         n_fail++; $display("FAIL post_reset_rgb: got %h expected %h", rgb, 24'h00FF00);
      end
   endtask

   initial begin
      n_checks                = 0;
      n_fail                  = 0;
      reset                   = 1'b0;
      display_frame_request   = 1'b0;
      vga_vertical_sync       = 1'b1;
      pixel_x_pos             = 10'd0;
      pixel_y_pos             = 10'd0;
      bus_if.bus_write_enable = 1'b0;
      bus_if.bus_read_enable  = 1'b0;
      bus_if.bus_address      = 18'd0;
      bus_if.bus_write_data   = 32'h0;
      bus_if.bus_byte_enable  = 4'h0;

      test_reset();
      test_write_read();
      test_upscale();
      test_byte_enable_range();
      test_deferred_swap();
      test_vsync_low_hold();
      test_glitch_request();
      test_reset_midframe();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
